// File: rtl/iir_deemph_scheduler.sv
// Shared single-multiplier IIR deemphasis engine, time-multiplexed between left
// and right channels with round-robin arbitration and per-channel history.
module iir_deemph_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int B0         = 178,
  parameter int B1         = 178,
  parameter int A1         = 576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_l,
  input  logic [DATA_WIDTH-1:0] din_r,
  input  logic [1:0]            in_valid,
  output logic [1:0]            in_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clear,
  output logic                  busy
);

  localparam logic signed [DATA_WIDTH-1:0] B0_Q = DATA_WIDTH'(B0);
  localparam logic signed [DATA_WIDTH-1:0] B1_Q = DATA_WIDTH'(B1);
  localparam logic signed [DATA_WIDTH-1:0] A1_Q = DATA_WIDTH'(A1);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DONE} state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic                         chan_q;
  logic                         last_served_q;
  logic signed [DATA_WIDTH-1:0] x_prev [0:1];
  logic signed [DATA_WIDTH-1:0] y_prev [0:1];

  logic                         grant;
  logic                         accept;
  logic signed [DATA_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0] opnd;
  logic signed [DATA_WIDTH-1:0] product;
  logic signed [DATA_WIDTH-1:0] dq;

  // On a tie the channel not served last wins; a lone request always wins.
  always_comb begin
    grant    = in_valid[1] & (~in_valid[0] | ~last_served_q);
    in_ready = '0;
    if (state_q == IDLE && reset && !clear && (|in_valid)) begin
      in_ready = grant ? 2'b10 : 2'b01;
    end
    accept = |(in_valid & in_ready);
  end

  // One multiplier; operands steered by the current step.
  always_comb begin
    coef = B0_Q;
    opnd = x_q;
    case (state_q)
      MUL1: begin
        coef = B1_Q;
        opnd = x_prev[chan_q];
      end
      MUL2: begin
        coef = A1_Q;
        opnd = y_prev[chan_q];
      end
      default: ;
    endcase
    product = coef * opnd;
    dq      = product >>> Q_BITS;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = MUL0;
        MUL0:    state_d = MUL1;
        MUL1:    state_d = MUL2;
        MUL2:    state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      acc_q         <= '0;
      chan_q        <= 1'b0;
      last_served_q <= 1'b1;
      x_prev[0]     <= '0;
      x_prev[1]     <= '0;
      y_prev[0]     <= '0;
      y_prev[1]     <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        x_prev[0] <= '0;
        x_prev[1] <= '0;
        y_prev[0] <= '0;
        y_prev[1] <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              x_q           <= grant ? din_r : din_l;
              chan_q        <= grant;
              last_served_q <= grant;
            end
          end
          MUL0: acc_q <= dq;
          MUL1: acc_q <= acc_q + dq;
          MUL2: acc_q <= acc_q + dq;
          DONE: begin
            // History commits only when the result is actually consumed.
            if (out_ready) begin
              x_prev[chan_q] <= x_q;
              y_prev[chan_q] <= acc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign dout      = acc_q;
  assign out_chan  = chan_q;
  assign busy      = (state_q != IDLE);

endmodule
